// File: rtl/jk_arb_pkg.sv
// ---------------------------------------------------------------------------
// jk_arb_pkg
//   Shared types and helpers for the JK flip-flop round-robin arbiter.
//   - jk_op_e     : 2-bit JK operation, encoded as {j,k}
//   - state_e     : controller FSM states
//   - jk_expected : q a healthy JK flip-flop should show after an operation
// ---------------------------------------------------------------------------
package jk_arb_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RESP
    } state_e;

    function automatic logic jk_expected(input jk_op_e op, input logic prev_q);
        case (op)
            JK_HOLD:  return prev_q;
            JK_RESET: return 1'b0;
            JK_SET:   return 1'b1;
            default:  return ~prev_q;
        endcase
    endfunction

endpackage

// File: rtl/jk_ff_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search. Scans req starting at ptr and wrapping
//   (ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1); the first set bit wins.
//   The pointer register lives in the parent.
// Ports:
//   req   [N_REQ-1:0] in   pending requests
//   ptr   [IDX_W-1:0] in   index searched first
//   found             out  at least one request is pending
//   idx   [IDX_W-1:0] out  winning requester (0 when found is low)
// ---------------------------------------------------------------------------
module rr_arbiter
    import jk_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a value before the loop so
        // no path leaves one unassigned, which would infer a latch.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/jk_ff_arbiter.sv
// ---------------------------------------------------------------------------
// jk_ff_arbiter
//   Shares one JK flip-flop among N_REQ requesters. A winner is picked
//   round-robin in IDLE, its op is driven onto valid/j/k for one cycle
//   (DRIVE), the flip-flop output is captured (SAMPLE) and returned with a
//   one-cycle one-hot ack (RESP). One operation every 4 cycles.
//   Optional macro JK_ARB_CHECK_EN adds a sticky consistency checker on err;
//   without it err is tied low.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   async active-high reset (also resets the flip-flop)
//   req        in   [N_REQ]    request per requester, held until ack
//   op         in   [2*N_REQ]  op[2i+1:2i] = {j,k} for requester i
//   ack        out  [N_REQ]    one-hot completion pulse
//   rsp_q      out  q captured for the acked requester
//   busy       out  high in every state except IDLE
//   grant_idx  out  [IDX_W]    current or last winner
//   valid/j/k  out  JK flip-flop update strobe and inputs
//   q/qb       in   JK flip-flop outputs
//   err        out  sticky consistency error
// ---------------------------------------------------------------------------
module jk_ff_arbiter
    import jk_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    output logic [N_REQ-1:0]   ack,
    output logic               rsp_q,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid,
    output logic               j,
    output logic               k,
    input  logic               q,
    input  logic               qb,
    output logic               err
);

    state_e           state;
    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [1:0]       win_op;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (win_idx)
    );

    // {win_idx, 0} is 2*win_idx without overflowing the index width.
    assign win_op = op[{win_idx, 1'b0} +: 2];

`ifdef JK_ARB_CHECK_EN
    jk_op_e op_lat;
`else
    logic unused_qb;
    assign unused_qb = qb;
    assign err       = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            ack       <= '0;
            rsp_q     <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
`ifdef JK_ARB_CHECK_EN
            op_lat    <= JK_HOLD;
            err       <= 1'b0;
`endif
        end else begin
            // Strobes default low; only the transition into DRIVE/RESP
            // raises them, giving exactly one-cycle pulses.
            ack   <= '0;
            valid <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= win_idx;
                        rr_ptr    <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        valid     <= 1'b1;
                        {j, k}    <= win_op;
                        busy      <= 1'b1;
`ifdef JK_ARB_CHECK_EN
                        op_lat    <= jk_op_e'(win_op);
`endif
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    // The flip-flop updated on the DRIVE->SAMPLE edge.
                    rsp_q <= q;
                    ack   <= N_REQ'(1) << grant_idx;
`ifdef JK_ARB_CHECK_EN
                    // rsp_q still holds the previous result here.
                    if ((q == qb) || (q != jk_expected(op_lat, rsp_q)))
                        err <= 1'b1;
`endif
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_ff_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jk_ff_arbiter
//   Self-checking bench for jk_ff_arbiter (N_REQ = 4). Contains a behavioural
//   JK flip-flop driving q/qb, a directed vector table, a mid-operation reset
//   sequence, a randomized phase against a transaction-level model, and the
//   err check (behaviour depends on JK_ARB_CHECK_EN).
// ---------------------------------------------------------------------------
module tb_jk_ff_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [N-1:0]   ack;
    logic           rsp_q;
    logic           busy;
    logic [1:0]     grant_idx;
    logic           valid;
    logic           j;
    logic           k;
    logic           q;
    logic           qb;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    jk_ff_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .ack       (ack),
        .rsp_q     (rsp_q),
        .busy      (busy),
        .grant_idx (grant_idx),
        .valid     (valid),
        .j         (j),
        .k         (k),
        .q         (q),
        .qb        (qb),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural JK flip-flop; corrupt forces qb equal to q.
    logic ff_q;
    logic corrupt = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset)
            ff_q <= 1'b0;
        else if (valid)
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
    end
    assign q  = ff_q;
    assign qb = corrupt ? ff_q : ~ff_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ack"},   ack,   0);
        check({tag, " valid"}, valid, 0);
        check({tag, " jk"},    {j, k}, 0);
        check({tag, " busy"},  busy,  0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req   = '0;
        #1;
        step();
        reset = 1'b0;
    endtask

    // One full transaction starting in IDLE; ends in the following IDLE cycle.
    task automatic do_txn(input logic [3:0] r, input logic [7:0] o, input int exp_idx,
                          input logic [3:0] exp_ack, input logic exp_q, input bit scramble);
        logic [7:0] sh;
        sh  = o >> (2 * exp_idx);
        req = r;
        op  = o;
        step();                                   // T+1: DRIVE
        check("drive valid", valid, 1);
        check("drive jk",    {j, k}, sh[1:0]);
        check("drive busy",  busy, 1);
        check("drive ack",   ack, 0);
        check("drive grant", grant_idx, exp_idx);
        if (scramble) begin
            op  = 8'($urandom);
            req = 4'($urandom);
        end
        step();                                   // T+2: SAMPLE
        check("sample valid", valid, 0);
        check("sample ack",   ack, 0);
        step();                                   // T+3: RESP
        check("resp ack",   ack, exp_ack);
        check("resp rsp_q", rsp_q, exp_q);
        check("resp busy",  busy, 1);
        check("resp grant", grant_idx, exp_idx);
        check("resp err",   err, 0);
        step();                                   // T+4: IDLE
        check("idle ack",  ack, 0);
        check("idle busy", busy, 0);
    endtask

    typedef struct {
        bit         pre_reset;
        logic [3:0] req;
        logic [7:0] op;
        int         idx;
        logic [3:0] ack;
        logic       q;
    } vec_t;

    vec_t vecs[12];

    int   mptr;
    logic mq;
    logic exp_err;

    initial begin
        // single request, then round robin from a fresh reset
        vecs[0]  = '{0, 4'b0001, 8'h02, 0, 4'b0001, 1'b1};
        vecs[1]  = '{1, 4'b1111, 8'hFF, 0, 4'b0001, 1'b1};
        vecs[2]  = '{0, 4'b1111, 8'hFF, 1, 4'b0010, 1'b0};
        vecs[3]  = '{0, 4'b1111, 8'hFF, 2, 4'b0100, 1'b1};
        vecs[4]  = '{0, 4'b1111, 8'hFF, 3, 4'b1000, 1'b0};
        vecs[5]  = '{0, 4'b1111, 8'hFF, 0, 4'b0001, 1'b1};
        // pointer wrap: 3 served, then 0 beats 3
        vecs[6]  = '{0, 4'b1000, 8'h00, 3, 4'b1000, 1'b1};
        vecs[7]  = '{0, 4'b1001, 8'hC1, 0, 4'b0001, 1'b0};
        // SET, HOLD, RESET
        vecs[8]  = '{0, 4'b0010, 8'h08, 1, 4'b0010, 1'b1};
        vecs[9]  = '{0, 4'b0100, 8'h00, 2, 4'b0100, 1'b1};
        vecs[10] = '{0, 4'b0100, 8'h10, 2, 4'b0100, 1'b0};
        // pointer at 3 wraps to 0 ahead of 1
        vecs[11] = '{0, 4'b0011, 8'h03, 0, 4'b0001, 1'b1};

        reset = 1'b1;
        req   = '0;
        op    = '0;
        #1;
        check("in-reset ack",  ack, 0);
        check("in-reset busy", busy, 0);
        step();
        step();
        reset = 1'b0;
        check_quiet("reset");
        check("reset rsp_q", rsp_q, 0);
        check("reset grant", grant_idx, 0);
        check("reset err",   err, 0);

        // Table-driven directed vectors
        foreach (vecs[i]) begin
            if (vecs[i].pre_reset) pulse_reset();
            do_txn(vecs[i].req, vecs[i].op, vecs[i].idx, vecs[i].ack, vecs[i].q, 1'b0);
        end
        req = '0;
        step();
        check_quiet("after table");

        // Reset asserted in SAMPLE: no ack, all outputs cleared, pointer 0
        req = 4'b0001;
        op  = 8'h02;
        step();                       // DRIVE (pointer moves to 1)
        step();                       // SAMPLE
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        check("midreset rsp_q", rsp_q, 0);
        check("midreset grant", grant_idx, 0);
        req = '0;
        step();
        check("midreset held ack", ack, 0);
        reset = 1'b0;
        step();
        check_quiet("after midreset");
        do_txn(4'b0011, 8'h0E, 0, 4'b0001, 1'b1, 1'b0);
        do_txn(4'b0010, 8'h0E, 1, 4'b0010, 1'b0, 1'b0);

        // Randomized phase against a transaction-level model
        pulse_reset();
        mptr = 0;
        mq   = 1'b0;
        for (int it = 0; it < 60; it++) begin
            logic [3:0] r;
            logic [7:0] o;
            logic [7:0] sh;
            int         w;
            r = 4'($urandom_range(0, 15));
            o = 8'($urandom);
            if (r == 0) begin
                req = '0;
                op  = o;
                step();
                check_quiet("rand idle");
            end else begin
                w = -1;
                for (int s = 0; s < N; s++) begin
                    int c;
                    c = (mptr + s) % N;
                    if (w < 0 && r[c]) w = c;
                end
                sh = o >> (2 * w);
                case (sh[1:0])
                    2'b01:   mq = 1'b0;
                    2'b10:   mq = 1'b1;
                    2'b11:   mq = ~mq;
                    default: mq = mq;
                endcase
                mptr = (w + 1) % N;
                do_txn(r, o, w, 4'(1 << w), mq, 1'b1);
            end
        end

        // Consistency checker: qb forced equal to q during SAMPLE
`ifdef JK_ARB_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        pulse_reset();
        check("err before", err, 0);
        req = 4'b0001;
        op  = 8'h02;
        step();                       // DRIVE
        step();                       // SAMPLE
        corrupt = 1'b1;
        step();                       // RESP
        corrupt = 1'b0;
        check("err ack",   ack, 4'b0001);
        check("err set",   err, exp_err);
        req = '0;
        step();
        step();
        step();
        check("err sticky", err, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_ff_arbiter.md
# jk_ff_arbiter

Round-robin controller sharing one JK flip-flop among N_REQ requesters. Each requester posts a 2-bit JK operation. The block grants one requester at a time and drives the flip-flop's valid/j/k inputs for exactly one cycle. It then samples q/qb and returns the resulting q to the winner with a one-cycle ack. It sits between test or control agents and the JK flip-flop behind the existing JK interface signals (valid, j, k, q, qb).

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(N_REQ), requester index width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; also drives the JK flip-flop reset
- req  input  N_REQ  request per requester; held high until its ack
- op  input  2*N_REQ  op[2i+1:2i] for requester i: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE ({j,k})
- ack  output  N_REQ  one-hot, one-cycle completion pulse
- rsp_q  output  1  q captured for the acked requester; valid while ack is nonzero
- busy  output  1  high in every state except IDLE
- grant_idx  output  IDX_W  index of the current or last winner
- valid  output  1  JK flip-flop update strobe
- j  output  1  JK j input
- k  output  1  JK k input
- q  input  1  JK output
- qb  input  1  JK complementary output
- err  output  1  sticky consistency error (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, RESP.
- IDLE:
  - if req is nonzero, select the winner by round-robin starting at pointer rr_ptr.
  - latch grant_idx and the winner's op, then go to DRIVE.
  - set rr_ptr to (winner+1) mod N_REQ.
- DRIVE: valid=1, {j,k}=latched op; go to SAMPLE.
- SAMPLE: the flip-flop has updated on the DRIVE→SAMPLE edge. Register q into rsp_q; go to RESP.
- RESP: ack[grant_idx]=1; go to IDLE.
- valid/j/k are 0 in every state except DRIVE.
- op is sampled only in IDLE. Later changes to op do not affect the transaction in flight.
- If req drops before ack, the transaction still completes and the ack is still issued.
- If req is still high in the IDLE cycle after ack, it is treated as a new request.
- rr_ptr wrap: the search order is rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, rr_ptr-1.
- HOLD is a legal op: full sequence, valid pulses with j=k=0, and q is unchanged.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_idx 0, ack 0, rsp_q 0, busy 0, valid/j/k 0, err 0.
- Assertion of reset mid-transaction aborts immediately with no ack. On release, the block starts fresh from IDLE.
- Latency: req seen in IDLE in cycle T gives valid in T+1, capture in T+2, and ack in T+3. The next arbitration happens in T+4.
- Throughput: one operation per 4 cycles. There is no back-to-back pipelining.
- ack is a single cycle and always one-hot.

## Configuration
- JK_ARB_CHECK_EN defined:
  - in SAMPLE, if q == qb, or q differs from the expected value, set err.
  - expected value: HOLD → previous rsp_q; RESET → 0; SET → 1; TOGGLE → ~previous rsp_q.
  - err stays set until reset.
- JK_ARB_CHECK_EN undefined: the err port is tied to 0 and no check logic exists.

## Structure
- Package jk_arb_pkg holds:
  - typedef enum logic [1:0] jk_op_e {JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE}.
  - typedef enum state_e {IDLE, DRIVE, SAMPLE, RESP}.
  - function jk_expected(op, prev_q).
- Sub-module rr_arbiter(N_REQ): combinational priority search from rr_ptr. Outputs a found flag and the winner index. The pointer register stays in the parent.

## Test plan
- Single request: req=0001, op0=SET, starting from q=0 after reset → valid=1/j=1/k=0 at T+1; ack=0001 and rsp_q=1 at T+3; busy low at T+4.
- Round-robin fairness: req=1111 held, ops all TOGGLE → grant order 0,1,2,3,0. Each ack is 4 cycles apart, and rsp_q alternates 1,0,1,0,1.
- Pointer wrap: req=1000 is served first; then req=1001 → requester 0 wins next.
- HOLD and RESET: op=HOLD after SET gives rsp_q=1; then op=RESET gives rsp_q=0.
- Reset mid-op: assert reset in the SAMPLE cycle → no ack, all outputs 0, rr_ptr=0. The next req=0010 completes normally.
- With JK_ARB_CHECK_EN: force qb=q during SAMPLE → err=1 and stays 1. Without the macro, err remains 0.
